// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register-read bundle: read ports, write-back ports, issue slots and stall status.
interface regfile_scoreboard_if #(
   parameter int unsigned ISSUE = 2,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned CNTW  = 16
);
   logic [ISSUE*AW-1:0]   rs_addr;
   logic [ISSUE*AW-1:0]   rt_addr;
   logic [ISSUE-1:0]      rs_used;
   logic [ISSUE-1:0]      rt_used;
   logic [ISSUE*XLEN-1:0] rs_data;
   logic [ISSUE*XLEN-1:0] rt_data;
   logic [ISSUE-1:0]      wb_we;
   logic [ISSUE*AW-1:0]   wb_addr;
   logic [ISSUE*XLEN-1:0] wb_data;
   logic [ISSUE-1:0]      wb_ld;
   logic [ISSUE-1:0]      iss_valid;
   logic [ISSUE*AW-1:0]   iss_dest;
   logic [ISSUE-1:0]      iss_ld;
   logic                  stall;
   logic [CNTW-1:0]       stall_cnt;

   modport master (
      output rs_addr, rt_addr, rs_used, rt_used,
      output wb_we, wb_addr, wb_data, wb_ld,
      output iss_valid, iss_dest, iss_ld,
      input  rs_data, rt_data, stall, stall_cnt
   );

   modport slave (
      input  rs_addr, rt_addr, rs_used, rt_used,
      input  wb_we, wb_addr, wb_data, wb_ld,
      input  iss_valid, iss_dest, iss_ld,
      output rs_data, rt_data, stall, stall_cnt
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// N-issue register file with write-through bypass, load busy scoreboard and
// bundle-wide load-use stall. Read data and stall are combinational by design.
module regfile_scoreboard #(
   parameter int unsigned ISSUE = 2,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned CNTW  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_scoreboard_if.slave  bus
);

   logic [XLEN-1:0]       regs_q [NREG];
   logic [XLEN-1:0]       regs_d [NREG];
   logic [NREG-1:0]       busy_q, busy_d;
   logic [NREG-1:0]       clr_c, set_c;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic                  stall_c, fire_c;
   logic [ISSUE*XLEN-1:0] rs_data_c, rt_data_c;
   logic [AW-1:0]         src_rs, src_rt, dst_i;

   // Storage read with youngest-port write-through bypass; r0 is hardwired zero.
   function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      v = regs_q[a];
      for (int p = 0; p < ISSUE; p++) begin
         if (bus.wb_we[p] && bus.wb_addr[p*AW +: AW] == a)
            v = bus.wb_data[p*XLEN +: XLEN];
      end
      if (a == '0)
         v = '0;
      return v;
   endfunction

   always_comb begin
      rs_data_c = '0;
      rt_data_c = '0;
      for (int i = 0; i < ISSUE; i++) begin
         rs_data_c[i*XLEN +: XLEN] = rd(bus.rs_addr[i*AW +: AW]);
         rt_data_c[i*XLEN +: XLEN] = rd(bus.rt_addr[i*AW +: AW]);
      end
   end

   always_comb begin
      clr_c = '0;
      for (int p = 0; p < ISSUE; p++) begin
         if (bus.wb_we[p] && bus.wb_ld[p])
            clr_c[bus.wb_addr[p*AW +: AW]] = 1'b1;
      end
   end

   // Hazard detection: busy source not being cleared now, or a source fed by an older load in the bundle.
   always_comb begin
      stall_c = 1'b0;
      src_rs  = '0;
      src_rt  = '0;
      dst_i   = '0;
      for (int j = 0; j < ISSUE; j++) begin
         src_rs = bus.rs_addr[j*AW +: AW];
         src_rt = bus.rt_addr[j*AW +: AW];
         if (bus.iss_valid[j]) begin
            if (bus.rs_used[j] && src_rs != '0 && busy_q[src_rs] && !clr_c[src_rs])
               stall_c = 1'b1;
            if (bus.rt_used[j] && src_rt != '0 && busy_q[src_rt] && !clr_c[src_rt])
               stall_c = 1'b1;
            for (int i = 0; i < j; i++) begin
               dst_i = bus.iss_dest[i*AW +: AW];
               if (bus.iss_valid[i] && bus.iss_ld[i] && dst_i != '0 &&
                   ((bus.rs_used[j] && src_rs == dst_i) || (bus.rt_used[j] && src_rt == dst_i)))
                  stall_c = 1'b1;
            end
         end
      end
   end

   assign fire_c = (|bus.iss_valid) && !stall_c;

   always_comb begin
      set_c = '0;
      if (fire_c) begin
         for (int i = 0; i < ISSUE; i++) begin
            if (bus.iss_valid[i] && bus.iss_ld[i])
               set_c[bus.iss_dest[i*AW +: AW]] = 1'b1;
         end
      end
      busy_d    = (busy_q & ~clr_c) | set_c;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      regs_d = regs_q;
      for (int p = 0; p < ISSUE; p++) begin
         if (bus.wb_we[p] && bus.wb_addr[p*AW +: AW] != '0)
            regs_d[bus.wb_addr[p*AW +: AW]] = bus.wb_data[p*XLEN +: XLEN];
      end
      regs_d[0] = '0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall_c && cnt_q != '1)
         cnt_d = cnt_q + CNTW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++)
            regs_q[r] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.rs_data   = rs_data_c;
   assign bus.rt_data   = rt_data_c;
   assign bus.stall     = stall_c;
   assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard (ISSUE=2, CNTW=4).
module tb_regfile_scoreboard;
   localparam int unsigned ISSUE = 2;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned CNTW  = 4;

   typedef struct {
      logic [AW-1:0]   rs0, rt0, rs1, rt1;
      logic [1:0]      rs_used, rt_used, wb_we, wb_ld, iss_valid, iss_ld;
      logic [AW-1:0]   wa0, wa1, d0, d1;
      logic [XLEN-1:0] wd0, wd1;
      logic [XLEN-1:0] e_rs0, e_rt0, e_rs1, e_rt1;
      logic            e_stall;
      logic [CNTW-1:0] e_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   regfile_scoreboard_if #(.ISSUE(ISSUE), .XLEN(XLEN), .AW(AW), .CNTW(CNTW)) bus ();

   regfile_scoreboard #(.ISSUE(ISSUE), .XLEN(XLEN), .NREG(32), .AW(AW), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t vz();
      vec_t v;
      v.rs0 = '0; v.rt0 = '0; v.rs1 = '0; v.rt1 = '0;
      v.rs_used = '0; v.rt_used = '0; v.wb_we = '0; v.wb_ld = '0;
      v.iss_valid = '0; v.iss_ld = '0;
      v.wa0 = '0; v.wa1 = '0; v.d0 = '0; v.d1 = '0; v.wd0 = '0; v.wd1 = '0;
      v.e_rs0 = '0; v.e_rt0 = '0; v.e_rs1 = '0; v.e_rt1 = '0;
      v.e_stall = 1'b0; v.e_cnt = '0;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.rs_addr   = {v.rs1, v.rs0};
      bus.rt_addr   = {v.rt1, v.rt0};
      bus.rs_used   = v.rs_used;
      bus.rt_used   = v.rt_used;
      bus.wb_we     = v.wb_we;
      bus.wb_ld     = v.wb_ld;
      bus.wb_addr   = {v.wa1, v.wa0};
      bus.wb_data   = {v.wd1, v.wd0};
      bus.iss_valid = v.iss_valid;
      bus.iss_dest  = {v.d1, v.d0};
      bus.iss_ld    = v.iss_ld;
   endtask

   task automatic chk(input string name, input int id, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, id, got, exp);
      end
   endtask

   task automatic check_all(input int id, input vec_t v);
      chk("rs0", id, bus.rs_data[0 +: XLEN], v.e_rs0);
      chk("rt0", id, bus.rt_data[0 +: XLEN], v.e_rt0);
      chk("rs1", id, bus.rs_data[XLEN +: XLEN], v.e_rs1);
      chk("rt1", id, bus.rt_data[XLEN +: XLEN], v.e_rt1);
      chk("stall", id, XLEN'(bus.stall), XLEN'(v.e_stall));
      chk("stall_cnt", id, XLEN'(bus.stall_cnt), XLEN'(v.e_cnt));
   endtask

   // Drive on the falling edge, sample 3 time units later, commit on the next rising edge.
   task automatic step(input int id, input vec_t v);
      @(negedge clk);
      drive(v);
      #3;
      check_all(id, v);
   endtask

   initial begin
      vec_t v;
      v = vz();
      // r5 written by both ports: port 1 wins, bypassed in the same cycle
      v.wb_we = 2'b11; v.wa0 = 5; v.wd0 = 32'h1111; v.wa1 = 5; v.wd1 = 32'h2222;
      v.rs0 = 5; v.rs_used = 2'b01; v.e_rs0 = 32'h2222; tbl.push_back(v);
      // storage holds 0x2222; write to r0 is bypass-masked
      v = vz(); v.rs0 = 5; v.rt1 = 5; v.rs_used = 2'b11; v.rt_used = 2'b10;
      v.wb_we = 2'b01; v.wa0 = 0; v.wd0 = 32'hDEAD;
      v.e_rs0 = 32'h2222; v.e_rt1 = 32'h2222; tbl.push_back(v);
      // r0 still zero; different-address bypass on both ports
      v = vz(); v.rs0 = 0; v.rt0 = 7; v.rs1 = 6; v.rs_used = 2'b11; v.rt_used = 2'b01;
      v.wb_we = 2'b11; v.wa0 = 6; v.wd0 = 32'h66; v.wa1 = 7; v.wd1 = 32'h77;
      v.e_rt0 = 32'h77; v.e_rs1 = 32'h66; tbl.push_back(v);
      // load to r8 fires
      v = vz(); v.iss_valid = 2'b01; v.iss_ld = 2'b01; v.d0 = 8; tbl.push_back(v);
      // reader of r8 stalls three cycles
      for (int k = 0; k < 3; k++) begin
         v = vz(); v.iss_valid = 2'b01; v.rs0 = 8; v.rs_used = 2'b01;
         v.e_stall = 1'b1; v.e_cnt = CNTW'(k); tbl.push_back(v);
      end
      // load write-back clears r8 and is bypassed
      v = vz(); v.iss_valid = 2'b01; v.rs0 = 8; v.rs_used = 2'b01;
      v.wb_we = 2'b01; v.wb_ld = 2'b01; v.wa0 = 8; v.wd0 = 32'hABCD;
      v.e_rs0 = 32'hABCD; v.e_cnt = 3; tbl.push_back(v);
      v = vz(); v.iss_valid = 2'b01; v.rs0 = 8; v.rs_used = 2'b01;
      v.e_rs0 = 32'hABCD; v.e_cnt = 3; tbl.push_back(v);
      // intra-bundle hazard: slot0 loads r9, slot1 reads rt=r9
      v = vz(); v.iss_valid = 2'b11; v.iss_ld = 2'b01; v.d0 = 9; v.rt1 = 9; v.rt_used = 2'b10;
      v.e_stall = 1'b1; v.e_cnt = 3; tbl.push_back(v);
      // same bundle, rt unused: fires and marks r9 busy
      v = vz(); v.iss_valid = 2'b11; v.iss_ld = 2'b01; v.d0 = 9; v.rt1 = 9; v.rt_used = 2'b00;
      v.e_cnt = 4; tbl.push_back(v);
      v = vz(); v.iss_valid = 2'b01; v.rs0 = 9; v.rs_used = 2'b01;
      v.e_stall = 1'b1; v.e_cnt = 4; tbl.push_back(v);
      // r9 cleared via bypass; same cycle slot1 load sets r10 while port1 clears r10
      v = vz(); v.iss_valid = 2'b11; v.iss_ld = 2'b10; v.d1 = 10; v.rs0 = 9; v.rs_used = 2'b01;
      v.wb_we = 2'b11; v.wb_ld = 2'b11; v.wa0 = 9; v.wd0 = 32'h99; v.wa1 = 10; v.wd1 = 32'h1010;
      v.e_rs0 = 32'h99; v.e_cnt = 5; tbl.push_back(v);
      // set won: r10 still busy
      v = vz(); v.iss_valid = 2'b01; v.rs0 = 10; v.rt0 = 9; v.rs_used = 2'b01; v.rt_used = 2'b01;
      v.e_rs0 = 32'h1010; v.e_rt0 = 32'h99; v.e_stall = 1'b1; v.e_cnt = 5; tbl.push_back(v);
      v = vz(); v.iss_valid = 2'b01; v.rs0 = 10; v.rs_used = 2'b01;
      v.wb_we = 2'b10; v.wb_ld = 2'b10; v.wa1 = 10; v.wd1 = 32'h2020;
      v.e_rs0 = 32'h2020; v.e_cnt = 6; tbl.push_back(v);
      // load r11 fires, setting up the saturation run
      v = vz(); v.iss_valid = 2'b01; v.iss_ld = 2'b01; v.d0 = 11; v.e_cnt = 6; tbl.push_back(v);

      drive(vz());
      #12;
      @(negedge clk);
      rst = 1'b0;
      #3;
      chk("reset_stall", -1, XLEN'(bus.stall), 32'h0);
      chk("reset_cnt", -1, XLEN'(bus.stall_cnt), 32'h0);

      // every register reads zero after reset on every read port
      for (int r = 1; r < 32; r++) begin
         v = vz(); v.rs0 = AW'(r); v.rt0 = AW'(r); v.rs1 = AW'(r); v.rt1 = AW'(r);
         v.rs_used = 2'b11; v.rt_used = 2'b11;
         step(100 + r, v);
      end

      for (int i = 0; i < tbl.size(); i++)
         step(i, tbl[i]);

      // hold a load-use hazard on r11: counter saturates at 15
      for (int k = 0; k < 20; k++) begin
         v = vz(); v.iss_valid = 2'b01; v.rs0 = 11; v.rs_used = 2'b01; v.rs1 = 5; v.rs_used[1] = 1'b1;
         v.e_rs1 = 32'h2222; v.e_stall = 1'b1;
         v.e_cnt = (6 + k > 15) ? CNTW'(15) : CNTW'(6 + k);
         step(200 + k, v);
      end

      // asynchronous reset in the middle of the stall
      #1 rst = 1'b1;
      #1;
      chk("rst_stall_clr", 300, XLEN'(bus.stall), 32'h0);
      chk("rst_cnt_clr", 300, XLEN'(bus.stall_cnt), 32'h0);
      chk("rst_reg_clr", 300, bus.rs_data[XLEN +: XLEN], 32'h0);

      // during reset: intra-bundle hazard still stalls, write-back is bypassed but discarded
      v = vz(); v.iss_valid = 2'b11; v.iss_ld = 2'b01; v.d0 = 3; v.rs1 = 3; v.rs_used = 2'b10;
      v.rt0 = 12; v.rt_used = 2'b01;
      v.wb_we = 2'b01; v.wb_ld = 2'b01; v.wa0 = 12; v.wd0 = 32'h55;
      drive(v);
      #1;
      chk("rst_intra_stall", 301, XLEN'(bus.stall), 32'h1);
      chk("rst_wb_bypass", 301, bus.rt_data[0 +: XLEN], 32'h55);
      @(negedge clk);
      rst = 1'b0;
      v = vz(); v.rs0 = 12; v.rt0 = 11; v.rs_used = 2'b01; v.rt_used = 2'b01; v.iss_valid = 2'b01;
      drive(v);
      #3;
      chk("wb_in_rst_dropped", 302, bus.rs_data[0 +: XLEN], 32'h0);
      chk("busy_r11_cleared", 302, XLEN'(bus.stall), 32'h0);
      chk("cnt_after_rst", 302, XLEN'(bus.stall_cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
